// File: rtl/adcs1008a_ahbl_drain_master_if.sv
// AHB-Lite bus bundle between the FIFO drain master and the ADC wrapper fabric.
// Transfer handshake: an address phase is HTRANS=NONSEQ and completes on the
// HCLK edge where HREADY=1; the data phase follows with HTRANS=IDLE and
// completes on the next edge where HREADY=1. The master holds
// HADDR/HTRANS/HWRITE/HWDATA stable while HREADY=0.
interface adcs1008a_ahbl_drain_master_if;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  modport master (
    output HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/adcs1008a_ahbl_drain_master.sv
// Drains the ADCS1008A sample FIFO into a circular word buffer on each FIFO-level
// interrupt: read FIFOLEVEL, move that many DATA words to memory, then clear ICR.
module adcs1008a_ahbl_drain_master #(
  parameter logic [31:0] ADC_BASE = 32'h4000_0000,
  parameter int          LVL_W    = 5,
  parameter int          CNT_W    = 16
) (
  input  logic                            HCLK,
  input  logic                            HRESET,
  input  logic                            start,
  input  logic                            stop,
  input  logic [31:0]                     dst_base,
  input  logic [CNT_W-1:0]                buf_len,
  input  logic                            adc_irq,
  adcs1008a_ahbl_drain_master_if.master   bus,
  output logic                            busy,
  output logic                            done,
  output logic [CNT_W-1:0]                wr_idx,
  output logic                            err,
  output logic [3:0]                      dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT_IRQ, S_LVL_A, S_LVL_D, S_DAT_A, S_DAT_D,
    S_WR_A, S_WR_D, S_CLR_A, S_CLR_D, S_ERR
  } state_t;

  localparam logic [31:0] ADDR_DATA  = ADC_BASE + 32'h0000_0018;
  localparam logic [31:0] ADDR_LVL   = ADC_BASE + 32'h0000_001C;
  localparam logic [31:0] ADDR_ICR   = ADC_BASE + 32'h0000_0F00;
  localparam logic [1:0]  HT_IDLE    = 2'b00;
  localparam logic [1:0]  HT_NONSEQ  = 2'b10;

  state_t             state_q, state_d;
  logic [31:0]        haddr_q, haddr_d;
  logic [1:0]         htrans_q, htrans_d;
  logic               hwrite_q, hwrite_d;
  logic [31:0]        hwdata_q, hwdata_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   wr_idx_q, wr_idx_d;
  logic               err_q, err_d;
  logic [31:0]        dst_q, dst_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [LVL_W-1:0]   lvl_q, lvl_d;
  logic [31:0]        sample_q, sample_d;
  logic               stop_pend_q, stop_pend_d;

  logic [CNT_W-1:0]   wr_inc;
  logic [LVL_W-1:0]   lvl_dec;
  logic [31:0]        wr_off;

  assign wr_inc  = wr_idx_q + 1'b1;
  assign lvl_dec = lvl_q - 1'b1;
  assign wr_off  = {{(32-CNT_W-2){1'b0}}, wr_idx_q, 2'b00};

  always_comb begin
    state_d     = state_q;
    haddr_d     = haddr_q;
    htrans_d    = HT_IDLE;
    hwrite_d    = 1'b0;
    hwdata_d    = hwdata_q;
    done_d      = 1'b0;
    wr_idx_d    = wr_idx_q;
    err_d       = err_q;
    dst_d       = dst_q;
    len_d       = len_q;
    lvl_d       = lvl_q;
    sample_d    = sample_q;
    stop_pend_d = stop_pend_q | stop;

    case (state_q)
      S_IDLE, S_ERR: begin
        // A disarmed engine has nothing for stop to act on; an accepted start also clears it.
        stop_pend_d = 1'b0;
        if (start && (buf_len != '0)) begin
          dst_d    = dst_base;
          len_d    = buf_len;
          wr_idx_d = '0;
          err_d    = 1'b0;
          state_d  = S_WAIT_IRQ;
        end
      end
      S_WAIT_IRQ: begin
        if (stop_pend_d) begin
          stop_pend_d = 1'b0;
          state_d     = S_IDLE;
        end else if (adc_irq) begin
          state_d = S_LVL_A;
        end
      end
      S_LVL_A: if (bus.HREADY) state_d = S_LVL_D;
      S_LVL_D: begin
        if (bus.HRESP) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end else if (bus.HREADY) begin
          lvl_d   = bus.HRDATA[LVL_W-1:0];
          state_d = (bus.HRDATA[LVL_W-1:0] == '0) ? S_CLR_A : S_DAT_A;
        end
      end
      S_DAT_A: if (bus.HREADY) state_d = S_DAT_D;
      S_DAT_D: begin
        if (bus.HRESP) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end else if (bus.HREADY) begin
          sample_d = bus.HRDATA;
          state_d  = S_WR_A;
        end
      end
      S_WR_A: if (bus.HREADY) state_d = S_WR_D;
      S_WR_D: begin
        if (bus.HRESP) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end else if (bus.HREADY) begin
          if (wr_inc == len_q) begin
            wr_idx_d = '0;
            done_d   = 1'b1;
          end else begin
            wr_idx_d = wr_inc;
          end
          lvl_d   = lvl_dec;
          state_d = (lvl_dec != '0) ? S_DAT_A : S_CLR_A;
        end
      end
      S_CLR_A: if (bus.HREADY) state_d = S_CLR_D;
      S_CLR_D: begin
        if (bus.HRESP) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end else if (bus.HREADY) begin
          state_d = S_WAIT_IRQ;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Bus outputs are registered, so they are derived from the state being entered.
    case (state_d)
      S_LVL_A: begin
        htrans_d = HT_NONSEQ;
        haddr_d  = ADDR_LVL;
      end
      S_DAT_A: begin
        htrans_d = HT_NONSEQ;
        haddr_d  = ADDR_DATA;
      end
      S_WR_A: begin
        htrans_d = HT_NONSEQ;
        haddr_d  = dst_q + wr_off;
        hwrite_d = 1'b1;
      end
      S_WR_D: begin
        hwrite_d = 1'b1;
        hwdata_d = sample_q;
      end
      S_CLR_A: begin
        htrans_d = HT_NONSEQ;
        haddr_d  = ADDR_ICR;
        hwrite_d = 1'b1;
      end
      S_CLR_D: begin
        hwrite_d = 1'b1;
        hwdata_d = 32'h0000_0001;
      end
      default: ;
    endcase

    busy_d = (state_d != S_IDLE) && (state_d != S_ERR);
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= S_IDLE;
      haddr_q     <= '0;
      htrans_q    <= HT_IDLE;
      hwrite_q    <= 1'b0;
      hwdata_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wr_idx_q    <= '0;
      err_q       <= 1'b0;
      dst_q       <= '0;
      len_q       <= '0;
      lvl_q       <= '0;
      sample_q    <= '0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      haddr_q     <= haddr_d;
      htrans_q    <= htrans_d;
      hwrite_q    <= hwrite_d;
      hwdata_q    <= hwdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      wr_idx_q    <= wr_idx_d;
      err_q       <= err_d;
      dst_q       <= dst_d;
      len_q       <= len_d;
      lvl_q       <= lvl_d;
      sample_q    <= sample_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  assign bus.HADDR  = haddr_q;
  assign bus.HTRANS = htrans_q;
  assign bus.HWRITE = hwrite_q;
  assign bus.HSIZE  = 3'b010;
  assign bus.HWDATA = hwdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign wr_idx     = wr_idx_q;
  assign err        = err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_adcs1008a_ahbl_drain_master.sv
// Bench for the ADC FIFO drain master: an ADC/memory responder plus a transfer-level
// model (expected transfer queue, buffer slot counter) checked on every cycle.
module tb_adcs1008a_ahbl_drain_master;

  localparam logic [1:0] K_LVL = 2'd0;
  localparam logic [1:0] K_DAT = 2'd1;
  localparam logic [1:0] K_BUF = 2'd2;
  localparam logic [1:0] K_ICR = 2'd3;

  // clock / reset
  logic HCLK = 1'b0;
  logic HRESET = 1'b1;
  always #5 HCLK = ~HCLK;

  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] dst_base = '0;
  logic [15:0] buf_len = '0;
  logic        adc_irq;
  logic        busy, done, err;
  logic [15:0] wr_idx;
  logic [3:0]  dbg_state;

  adcs1008a_ahbl_drain_master_if bus_if ();

  adcs1008a_ahbl_drain_master dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .start     (start),
    .stop      (stop),
    .dst_base  (dst_base),
    .buf_len   (buf_len),
    .adc_irq   (adc_irq),
    .bus       (bus_if.master),
    .busy      (busy),
    .done      (done),
    .wr_idx    (wr_idx),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // scoreboard state
  int checks = 0;
  int failures = 0;
  logic [33:0] exp_q[$];          // {kind, expected write data}
  logic [31:0] adc_fifo[$];
  logic [31:0] mem [logic [31:0]];
  int          irq_seq = 0;
  int          icr_cnt = 0;
  int          ws = 0;
  logic        inject_err = 1'b0;
  int          dn_cnt = 0;
  int          bufw_cnt = 0;
  int          done_at_write = 0;
  int          max_run = 0;

  assign adc_irq = (irq_seq > icr_cnt);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // model + responder + per-cycle compare
  logic [15:0] model_idx = '0;
  logic [31:0] m_dst = '0;
  logic [15:0] m_len = '0;
  logic        exp_done = 1'b0;
  logic        in_dp = 1'b0;
  logic [1:0]  dp_kind = K_LVL;
  logic [31:0] dp_addr = '0;
  logic [31:0] dp_data = '0;
  logic [1:0]  p_htrans = 2'b00;
  logic        p_hready = 1'b1;
  logic        p_hresp = 1'b0;
  logic [31:0] p_haddr = '0;
  logic [31:0] p_hwdata = '0;
  logic        p_start = 1'b0;
  logic [15:0] p_buf_len = '0;
  logic [31:0] p_dst = '0;
  int          wcnt = 0;
  int          run = 0;

  always @(negedge HCLK) begin
    logic [31:0] ea;
    logic        ew;
    logic        hr;
    if (HRESET) begin
      in_dp = 1'b0;
      model_idx = '0;
      exp_done = 1'b0;
      wcnt = ws;
      run = 0;
      bus_if.HREADY = 1'b1;
      bus_if.HRESP = 1'b0;
      bus_if.HRDATA = '0;
      p_htrans = 2'b00;
      p_hready = 1'b1;
      p_hresp = 1'b0;
      p_start = 1'b0;
    end else begin
      exp_done = 1'b0;
      if (p_start && (p_buf_len != 16'd0)) begin
        model_idx = '0;
        m_dst = p_dst;
        m_len = p_buf_len;
      end
      if (in_dp && p_hready) begin
        case (dp_kind)
          K_DAT: if (!p_hresp && adc_fifo.size() != 0) adc_fifo.delete(0);
          K_BUF: begin
            mem[dp_addr] = p_hwdata;
            bufw_cnt++;
            if (model_idx + 16'd1 == m_len) begin
              model_idx = '0;
              exp_done = 1'b1;
              done_at_write = bufw_cnt;
            end else begin
              model_idx = model_idx + 16'd1;
            end
          end
          K_ICR: if (p_hwdata == 32'h1) icr_cnt++;
          default: ;
        endcase
        in_dp = 1'b0;
      end else if (p_htrans == 2'b10 && p_hready && exp_q.size() != 0) begin
        in_dp = 1'b1;
        dp_kind = exp_q[0][33:32];
        dp_data = exp_q[0][31:0];
        dp_addr = p_haddr;
        exp_q.delete(0);
      end

      chk("done", {31'd0, done}, {31'd0, exp_done});
      chk("wr_idx", {16'd0, wr_idx}, {16'd0, model_idx});
      if (done) dn_cnt++;
      if (bus_if.HTRANS == 2'b10) begin
        run++;
        if (run > max_run) max_run = run;
        if (in_dp) chk("nonseq_in_data_phase", {30'd0, bus_if.HTRANS}, 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_xfer actual=%h expected=none at %0t", bus_if.HADDR, $time);
        end else begin
          case (exp_q[0][33:32])
            K_LVL: begin ea = 32'h4000_001C; ew = 1'b0; end
            K_DAT: begin ea = 32'h4000_0018; ew = 1'b0; end
            K_BUF: begin ea = m_dst + {14'd0, model_idx, 2'b00}; ew = 1'b1; end
            default: begin ea = 32'h4000_0F00; ew = 1'b1; end
          endcase
          chk("haddr", bus_if.HADDR, ea);
          chk("hwrite", {31'd0, bus_if.HWRITE}, {31'd0, ew});
          chk("hsize", {29'd0, bus_if.HSIZE}, 32'd2);
        end
      end else begin
        run = 0;
        chk("htrans_idle", {30'd0, bus_if.HTRANS}, 32'd0);
      end
      if (in_dp && (dp_kind == K_BUF || dp_kind == K_ICR))
        chk("hwdata", bus_if.HWDATA, dp_data);

      // responder drive for the coming edge
      if (bus_if.HTRANS == 2'b10 || in_dp) begin
        if (wcnt == 0) begin
          hr = 1'b1;
          wcnt = ws;
        end else begin
          hr = 1'b0;
          wcnt--;
        end
      end else begin
        hr = 1'b1;
        wcnt = ws;
      end
      bus_if.HREADY = hr;
      bus_if.HRESP = in_dp && hr && (dp_kind == K_DAT) && inject_err;
      if (in_dp && dp_kind == K_LVL) bus_if.HRDATA = adc_fifo.size();
      else if (in_dp && dp_kind == K_DAT) bus_if.HRDATA = (adc_fifo.size() != 0) ? adc_fifo[0] : 32'hDEAD_BEEF;
      else bus_if.HRDATA = '0;

      p_htrans = bus_if.HTRANS;
      p_haddr = bus_if.HADDR;
      p_hwdata = bus_if.HWDATA;
      p_hready = hr;
      p_hresp = bus_if.HRESP;
      p_start = start;
      p_buf_len = buf_len;
      p_dst = dst_base;
    end
  end

  // driver tasks
  task automatic do_start(input logic [31:0] d, input logic [15:0] l);
    @(posedge HCLK); #2;
    dst_base = d;
    buf_len = l;
    start = 1'b1;
    @(posedge HCLK); #2;
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(posedge HCLK); #2;
    stop = 1'b1;
    @(posedge HCLK); #2;
    stop = 1'b0;
  endtask

  task automatic launch(input int n, input logic [31:0] first, input logic [31:0] step);
    exp_q.push_back({K_LVL, 32'd0});
    for (int k = 0; k < n; k++) begin
      adc_fifo.push_back(first + step * k);
      exp_q.push_back({K_DAT, 32'd0});
      exp_q.push_back({K_BUF, first + step * k});
    end
    exp_q.push_back({K_ICR, 32'd1});
    @(posedge HCLK); #2;
    irq_seq = icr_cnt + 1;
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || in_dp) && k < budget) begin
      @(posedge HCLK);
      k++;
    end
    if (k >= budget) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d expected=0 pending at %0t", exp_q.size(), $time);
      exp_q.delete();
    end
    repeat (4) @(posedge HCLK);
  endtask

  task automatic disarm();
    int k = 0;
    pulse_stop();
    while (busy && k < 20) begin
      @(posedge HCLK);
      k++;
    end
    #1;
    chk("disarm_busy", {31'd0, busy}, 32'd0);
  endtask

  function automatic logic [31:0] memv(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'hBAD0_BAD0;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int icr0;
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    chk("rst_htrans", {30'd0, bus_if.HTRANS}, 32'd0);
    chk("rst_haddr", bus_if.HADDR, 32'd0);
    chk("rst_hwrite", {31'd0, bus_if.HWRITE}, 32'd0);
    chk("rst_hwdata", bus_if.HWDATA, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_wr_idx", {16'd0, wr_idx}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    @(posedge HCLK); #2;
    HRESET = 1'b0;

    // basic batch of three
    do_start(32'h2000_0000, 16'd8);
    #1 chk("t1_busy", {31'd0, busy}, 32'd1);
    icr0 = icr_cnt;
    dn_cnt = 0;
    launch(3, 32'h11, 32'h11);
    wait_drain(200);
    chk("t1_m0", memv(32'h2000_0000), 32'h11);
    chk("t1_m1", memv(32'h2000_0004), 32'h22);
    chk("t1_m2", memv(32'h2000_0008), 32'h33);
    chk("t1_icr", icr_cnt - icr0, 32'd1);
    chk("t1_wr_idx", {16'd0, wr_idx}, 32'd3);
    chk("t1_done_cnt", dn_cnt, 32'd0);

    // same batch with two wait states per phase
    disarm();
    mem.delete();
    ws = 2;
    max_run = 0;
    do_start(32'h2000_0000, 16'd8);
    launch(3, 32'h11, 32'h11);
    wait_drain(400);
    chk("t3_m0", memv(32'h2000_0000), 32'h11);
    chk("t3_m1", memv(32'h2000_0004), 32'h22);
    chk("t3_m2", memv(32'h2000_0008), 32'h33);
    chk("t3_wr_idx", {16'd0, wr_idx}, 32'd3);
    chk("t3_addr_hold_len", max_run, 32'd3);
    ws = 0;

    // wrap with buf_len=4 over two batches
    disarm();
    dn_cnt = 0;
    bufw_cnt = 0;
    done_at_write = 0;
    do_start(32'h3000_0000, 16'd4);
    launch(3, 32'hA1, 32'h1);
    wait_drain(200);
    launch(3, 32'hA4, 32'h1);
    wait_drain(200);
    chk("t2_done_cnt", dn_cnt, 32'd1);
    chk("t2_done_at", done_at_write, 32'd4);
    chk("t2_wr_idx", {16'd0, wr_idx}, 32'd2);
    chk("t2_s0", memv(32'h3000_0000), 32'hA5);
    chk("t2_s1", memv(32'h3000_0004), 32'hA6);
    chk("t2_s2", memv(32'h3000_0008), 32'hA3);
    chk("t2_s3", memv(32'h3000_000C), 32'hA4);

    // empty FIFO: only level read and ICR clear, then engine still serves irqs
    icr0 = icr_cnt;
    launch(0, 32'h0, 32'h0);
    wait_drain(100);
    chk("t4_icr", icr_cnt - icr0, 32'd1);
    chk("t4_busy", {31'd0, busy}, 32'd1);
    launch(1, 32'h44, 32'h0);
    wait_drain(100);
    chk("t4_next", memv(32'h3000_0008), 32'h44);
    chk("t4_wr_idx", {16'd0, wr_idx}, 32'd3);

    // stop mid-batch
    disarm();
    do_start(32'h1000_0000, 16'd16);
    launch(2, 32'h5, 32'h1);
    repeat (2) @(posedge HCLK);
    pulse_stop();
    wait_drain(200);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_m0", memv(32'h1000_0000), 32'h5);
    chk("t5_m1", memv(32'h1000_0004), 32'h6);
    adc_fifo.push_back(32'h7);
    @(posedge HCLK); #2;
    irq_seq = icr_cnt + 1;
    repeat (20) @(posedge HCLK);
    #1;
    chk("t5_idle_busy", {31'd0, busy}, 32'd0);
    chk("t5_idle_wr_idx", {16'd0, wr_idx}, 32'd2);
    irq_seq = icr_cnt;
    adc_fifo.delete();

    // start with zero length is ignored
    do_start(32'h7000_0000, 16'd0);
    repeat (5) @(posedge HCLK);
    #1;
    chk("t6_busy", {31'd0, busy}, 32'd0);

    // error response on the DATA read, then recovery by start
    do_start(32'h5000_0000, 16'd8);
    inject_err = 1'b1;
    adc_fifo.push_back(32'hAA);
    adc_fifo.push_back(32'hBB);
    exp_q.push_back({K_LVL, 32'd0});
    exp_q.push_back({K_DAT, 32'd0});
    @(posedge HCLK); #2;
    irq_seq = icr_cnt + 1;
    wait_drain(100);
    chk("t7_err", {31'd0, err}, 32'd1);
    chk("t7_htrans", {30'd0, bus_if.HTRANS}, 32'd0);
    chk("t7_busy", {31'd0, busy}, 32'd0);
    inject_err = 1'b0;
    exp_q.push_back({K_LVL, 32'd0});
    exp_q.push_back({K_DAT, 32'd0});
    exp_q.push_back({K_BUF, 32'hAA});
    exp_q.push_back({K_DAT, 32'd0});
    exp_q.push_back({K_BUF, 32'hBB});
    exp_q.push_back({K_ICR, 32'd1});
    do_start(32'h5000_0000, 16'd8);
    wait_drain(200);
    chk("t7_err_clr", {31'd0, err}, 32'd0);
    chk("t7_m0", memv(32'h5000_0000), 32'hAA);
    chk("t7_m1", memv(32'h5000_0004), 32'hBB);
    chk("t7_wr_idx", {16'd0, wr_idx}, 32'd2);
    chk("t7_busy_rearm", {31'd0, busy}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adcs1008a_ahbl_drain_master.md
Name: adcs1008a_ahbl_drain_master

Overview:
AHB-Lite initiator that services the ADCS1008A controller's FIFO without CPU involvement. On the controller's FIFO-level interrupt, it performs these steps in order:
- reads FIFOLEVEL;
- reads DATA once per queued sample and writes each sample into a circular word buffer in system memory;
- clears the interrupt via ICR.

It sits on the same AHB-Lite fabric as the ADC wrapper and acts as the master counterpart of that responder.

Parameters:
ADC_BASE, 32'h4000_0000, base address of the ADC wrapper register block
LVL_W, 5, width of the FIFO level field taken from FIFOLEVEL read data (bits LVL_W-1:0)
CNT_W, 16, width of buffer length and index

Ports:
HCLK  in  1  bus clock, the only clock
HRESET  in  1  reset, synchronous, active-high
start  in  1  one-cycle pulse; arms the engine
stop  in  1  one-cycle pulse; disarms after the current batch completes
dst_base  in  32  word-aligned buffer base, sampled on start
buf_len  in  CNT_W  buffer length in words, sampled on start; 0 means start is ignored
adc_irq  in  1  ADC wrapper irq (level)
HADDR  out  32  address
HTRANS  out  2  IDLE=00, NONSEQ=10 only
HWRITE  out  1  write strobe
HSIZE  out  3  always 3'b010
HWDATA  out  32  write data
HRDATA  in  32  read data
HREADY  in  1  bus ready
HRESP  in  1  error response
busy  out  1  engine armed or mid-batch
done  out  1  one-cycle pulse when wr_idx wraps to 0
wr_idx  out  CNT_W  next buffer slot
err  out  1  sticky; set on HRESP=1

Behaviour:
- Reset state: HTRANS=00, HADDR=0, HWRITE=0, HWDATA=0, busy=0, done=0, wr_idx=0, err=0, FSM=IDLE. Reset mid-transfer abandons the transfer at once.
- Transfer model:
  - Single, non-pipelined transfers.
  - Address phase: HTRANS=NONSEQ, HADDR/HWRITE valid. It completes on the HCLK edge where HREADY=1; outputs are held while HREADY=0.
  - Data phase: the next cycle onward, with HTRANS=IDLE. It completes on the edge where HREADY=1.
  - Read data is captured on that edge. HWDATA is driven for the whole data phase.
- FSM states: IDLE, WAIT_IRQ, LVL_A, LVL_D, DAT_A, DAT_D, WR_A, WR_D, CLR_A, CLR_D, ERR.
- IDLE:
  - start with buf_len!=0 latches dst_base and buf_len, sets wr_idx=0 and busy=1, then goes to WAIT_IRQ.
  - start with buf_len=0 has no effect.
- WAIT_IRQ:
  - adc_irq=1 goes to LVL_A.
  - If stop is pending, go to IDLE with busy=0.
- LVL_A/LVL_D: read ADC_BASE+0x1C. lvl = HRDATA[LVL_W-1:0]. If lvl=0 go to CLR_A, else go to DAT_A.
- DAT_A/DAT_D: read ADC_BASE+0x18 and latch the sample.
- WR_A/WR_D: write the sample to dst_base + {wr_idx,2'b00}.
  - On completion, wr_idx increments. If it reaches buf_len it wraps to 0 and done pulses in the same cycle.
  - Decrement lvl. If lvl is nonzero go to DAT_A, else go to CLR_A.
- CLR_A/CLR_D: write 32'h1 to ADC_BASE+0xF00, then go to WAIT_IRQ.
- Stop handling:
  - stop sets a pending flag, which is honoured only in WAIT_IRQ.
  - start while busy is ignored.
  - start and stop in the same cycle while IDLE: start wins and pending stop is cleared.
- Error handling:
  - HRESP=1 in any data phase sets err and goes to ERR, driving HTRANS=IDLE.
  - ERR holds until start, which clears err and re-arms as from IDLE. busy=0 in ERR.
- Address arithmetic wraps modulo 2^32.

Test Plan:
- Reset, then start with dst_base=0x2000_0000, buf_len=8; FIFOLEVEL returns 3; DATA returns 0x11,0x22,0x33 -> writes 0x11@0x2000_0000, 0x22@0x2000_0004, 0x33@0x2000_0008, then ICR write of 1 @ADC_BASE+0xF00; wr_idx=3; done stays 0.
- buf_len=4 with two batches of level 3 -> 6 writes to slots 0,1,2,3,0,1; done pulses once on the 4th write; final wr_idx=2.
- Responder inserts 2 wait states on every transfer -> HADDR/HTRANS held stable while HREADY=0; same data and addresses as the no-wait case.
- FIFOLEVEL returns 0 -> no DATA reads; the next transfer is the ICR clear; FSM returns to WAIT_IRQ.
- stop asserted mid-batch with level 2 -> both samples written and ICR cleared, then busy=0; the next adc_irq causes no transfers.
- HRESP=1 on the DATA read -> err=1, HTRANS=00, busy=0; a later start clears err and the engine resumes.
